mem_req_scheduler: RTL and testbench

//  Shares one single-ported memory between the instruction-fetch and data load/store ports of the core.

---
 rtl/mem_req_scheduler.sv | 148 ++++++++++++++
 tb/tb_mem_req_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// Round-robin arbitration, one outstanding transaction, watchdog abort on silent memory.
module mem_req_scheduler #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_wr,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              busy,
    output logic              mem_valid,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [1:0]      state_r;
    logic            owner_d_r;
    logic            last_grant_d_r;
    logic [WD_W-1:0] wd_r;
    logic            grant_v_s;
    logic            grant_d_s;

    // On a tie the port that did not win last time is served.
    function automatic logic pick_d(input logic ireq, input logic dreq, input logic last_d);
        pick_d = dreq & (~ireq | ~last_d);
    endfunction

    // Arbitration decision for the IDLE state.
    always_comb begin
        grant_v_s = 1'b0;
        grant_d_s = 1'b0;
        if (i_req || d_req) begin
            grant_v_s = 1'b1;
            grant_d_s = pick_d(i_req, d_req, last_grant_d_r);
        end else begin
            grant_v_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            owner_d_r      <= 1'b0;
            last_grant_d_r <= 1'b1;
            wd_r           <= '0;
            i_ready        <= 1'b0;
            i_err          <= 1'b0;
            i_rdata        <= '0;
            d_ready        <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
            busy           <= 1'b0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_wr         <= 1'b0;
            mem_wdata      <= '0;
        end else begin
            i_ready <= 1'b0;
            i_err   <= 1'b0;
            d_ready <= 1'b0;
            d_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_v_s) begin
                        owner_d_r      <= grant_d_s;
                        last_grant_d_r <= grant_d_s;
                        mem_addr       <= grant_d_s ? d_addr : i_addr;
                        mem_wr         <= grant_d_s & d_wr;
                        if (grant_d_s) begin
                            mem_wdata <= d_wdata;
                        end
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_busy) begin
                        mem_valid <= 1'b0;
                        wd_r      <= '0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        if (owner_d_r) begin
                            d_ready <= 1'b1;
                            // Stores keep the last load result visible.
                            if (!mem_wr) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                        state_r <= ST_RESP;
                    end else if (wd_r == WD_LAST) begin
                        if (owner_d_r) begin
                            d_err <= 1'b1;
                        end else begin
                            i_err <= 1'b1;
                        end
                        state_r <= ST_RESP;
                    end else begin
                        wd_r <= wd_r + WD_ONE;
                    end
                end
                ST_RESP: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Scoreboard bench for mem_req_scheduler: directed vectors, queued expectations,
// a behavioural memory with programmable latency and a pulse monitor.
module tb_mem_req_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ready, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_ready, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        busy, mem_valid, mem_busy, mem_wr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_req_scheduler #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr(d_wr),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .busy(busy), .mem_valid(mem_valid), .mem_busy(mem_busy), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port_d;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          i_left = 0;
    int          d_left = 0;
    int          lat = 2;
    int          pend = 0;
    int          acc_cnt = 0;
    int          acc_edge = 0;
    logic        mute = 1'b0;
    logic        stray = 1'b0;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_wr;

    always @(posedge clk) cyc = cyc + 1;

    // Memory model: registers acceptances, answers lat cycles later unless muted.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            mem_ready = 1'b0;
            if (stray) begin
                mem_ready = 1'b1;
                stray = 1'b0;
            end
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) mem_ready = 1'b1;
            end
            if (mem_valid && !mem_busy) begin
                acc_cnt   = acc_cnt + 1;
                acc_edge  = cyc + 1;
                acc_addr  = mem_addr;
                acc_wr    = mem_wr;
                acc_wdata = mem_wdata;
                mem_rdata = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
                if (!mute) pend = lat;
            end
        end
    end

    // Requesters: on completion advance the address and drop req when done.
    always @(negedge clk) begin
        if (i_ready || i_err) begin
            if (i_left > 0) i_left = i_left - 1;
            i_addr = i_addr + 32'd4;
            if (i_left == 0) i_req = 1'b0;
        end
        if (d_ready || d_err) begin
            if (d_left > 0) d_left = d_left - 1;
            d_addr = d_addr + 32'd4;
            if (d_left == 0) d_req = 1'b0;
        end
    end

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int   npulse;
        exp_t e;
        logic got_d, got_err;
        logic [31:0] got_rd;
        npulse = int'(i_ready) + int'(i_err) + int'(d_ready) + int'(d_err);
        if (npulse != 0) begin
            checks = checks + 1;
            if (npulse > 1 || exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: i_ready=%0b i_err=%0b d_ready=%0b d_err=%0b queued=%0d required none",
                         i_ready, i_err, d_ready, d_err, exp_q.size());
            end else begin
                e       = exp_q.pop_front();
                got_d   = d_ready | d_err;
                got_err = i_err | d_err;
                got_rd  = got_d ? d_rdata : i_rdata;
                if (got_d !== e.port_d || got_err !== e.err || got_rd !== e.rdata ||
                    (e.lat >= 0 && (cyc - acc_edge) != e.lat)) begin
                    errors = errors + 1;
                    $display("FAIL response: got port_d=%0b err=%0b rdata=%h lat=%0d, required port_d=%0b err=%0b rdata=%h lat=%0d",
                             got_d, got_err, got_rd, cyc - acc_edge, e.port_d, e.err, e.rdata, e.lat);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic push_exp(input logic pd, input logic er, input logic [31:0] rd, input int l);
        exp_t e;
        e.port_d = pd; e.err = er; e.rdata = rd; e.lat = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((i_left != 0 || d_left != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_timeout"}, 64'(n < 300), 64'd1);
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {i_ready, i_err, d_ready, d_err, busy, mem_valid, mem_wr},
              64'd0);
        check({nm, "_data"}, {i_rdata, d_rdata} | {mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wr = 1'b0;
        mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);

        // Contention: I,D,I,D with distinct data per acceptance.
        rsp_q.push_back(32'h1111_0001); rsp_q.push_back(32'h2222_0001);
        rsp_q.push_back(32'h1111_0002); rsp_q.push_back(32'h2222_0002);
        push_exp(1'b0, 1'b0, 32'h1111_0001, -1);
        push_exp(1'b1, 1'b0, 32'h2222_0001, -1);
        push_exp(1'b0, 1'b0, 32'h1111_0002, -1);
        push_exp(1'b1, 1'b0, 32'h2222_0002, -1);
        lat = 2;
        i_addr = 32'h10; d_addr = 32'h20; d_wr = 1'b0;
        i_left = 2; d_left = 2; i_req = 1'b1; d_req = 1'b1;
        wait_done("contention");
        check("contention_accepts", 64'(acc_cnt), 64'd4);

        // Single fetch.
        @(negedge clk);
        rsp_q.push_back(32'hDEAD_BEEF);
        push_exp(1'b0, 1'b0, 32'hDEAD_BEEF, 2);
        i_addr = 32'h100; i_left = 1; i_req = 1'b1;
        @(negedge clk);
        check("fetch_mem_valid", {mem_valid, busy, mem_addr}, {1'b1, 1'b1, 32'h100});
        wait_done("fetch");
        check("fetch_fields", {acc_wr, acc_addr}, {1'b0, 32'h100});

        // Store: d_rdata keeps the last load value.
        @(negedge clk);
        push_exp(1'b1, 1'b0, 32'h2222_0002, 2);
        d_addr = 32'h2000; d_wdata = 32'h1234_5678; d_wr = 1'b1; d_left = 1; d_req = 1'b1;
        wait_done("store");
        check("store_fields", {acc_wr, acc_addr, acc_wdata}, {1'b1, 32'h2000, 32'h1234_5678});

        // Backpressure: five busy cycles with a field change after grant.
        @(negedge clk);
        base = acc_cnt;
        lat = 1;
        mem_busy = 1'b1;
        rsp_q.push_back(32'h0BAD_F00D);
        push_exp(1'b1, 1'b0, 32'h0BAD_F00D, -1);
        d_addr = 32'h3000; d_wr = 1'b0; d_left = 1; d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold", {mem_valid, mem_wr, mem_addr, 32'(acc_cnt - base)},
                  {1'b1, 1'b0, 32'h3000, 32'd0});
            d_addr = 32'h3FFC;
        end
        mem_busy = 1'b0;
        wait_done("backpressure");
        check("bp_accept", {32'(acc_cnt - base), acc_addr}, {32'd1, 32'h3000});

        // Timeout: memory silent, err 8 cycles after accept, rdata unchanged.
        @(negedge clk);
        mute = 1'b1;
        rsp_q.push_back(32'hFFFF_FFFF);
        push_exp(1'b1, 1'b1, 32'h0BAD_F00D, 8);
        d_addr = 32'h4000; d_left = 1; d_req = 1'b1;
        wait_done("timeout");
        mute = 1'b0;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        rsp_q.push_back(32'hCAFE_F00D);
        lat = 3;
        push_exp(1'b1, 1'b0, 32'hCAFE_F00D, 3);
        d_addr = 32'h4004; d_left = 1; d_req = 1'b1;
        wait_done("after_timeout");

        // Reset while waiting for the memory.
        @(negedge clk);
        lat = 5;
        base = acc_cnt;
        rsp_q.push_back(32'h5555_5555);
        i_addr = 32'h500; i_left = 1; i_req = 1'b1;
        for (int k = 0; k < 20 && acc_cnt == base; k++) @(negedge clk);
        check("rst_wait_accept", 64'(acc_cnt - base), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0; i_left = 0; i_req = 1'b0;
        @(negedge clk);
        check_all_zero("reset_in_wait");
        reset = 1'b1;
        repeat (8) @(negedge clk);
        rsp_q.push_back(32'h6666_6666);
        lat = 2;
        push_exp(1'b0, 1'b0, 32'h6666_6666, 2);
        i_addr = 32'h600; i_left = 1; i_req = 1'b1;
        wait_done("fetch_after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
